// File: rtl/store_pkg.sv
// Shared definitions for the tile store engine: FSM state encoding and the
// per-beat element-enable mask helper.
package store_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_TILE,
    WRITE,
    ADVANCE,
    FINISH
  } store_state_t;

  localparam int unsigned MAX_BEAT_ELEMS = 32;

  // Sets the low 'count' bits; callers size-cast down to their beat width.
  function automatic logic [MAX_BEAT_ELEMS-1:0] be_mask(input logic [31:0] count);
    logic [MAX_BEAT_ELEMS-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(MAX_BEAT_ELEMS); i++) begin
      mask[i] = (32'(i) < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/tile_beat_mux.sv
// Holds one captured buffer tile and selects the elements of the current beat,
// forcing disabled lanes to zero.
module tile_beat_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_ELEMS = 32,
  parameter int BEAT_ELEMS = 4,
  parameter int BEAT_IDX_W = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            capture,
  input  logic [DATA_WIDTH-1:0]           tile_data [TILE_ELEMS],
  input  logic [BEAT_IDX_W-1:0]           beat_idx,
  input  logic [BEAT_ELEMS-1:0]           lane_en,
  output logic [BEAT_ELEMS*DATA_WIDTH-1:0] beat_data
);

  localparam int ELEM_IDX_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

  logic [DATA_WIDTH-1:0] tile_reg [TILE_ELEMS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_ELEMS; i++) tile_reg[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < TILE_ELEMS; i++) tile_reg[i] <= tile_data[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEAT_ELEMS; gi++) begin : g_lane
      logic [ELEM_IDX_W-1:0] elem_idx;
      assign elem_idx = ELEM_IDX_W'(beat_idx) * ELEM_IDX_W'(BEAT_ELEMS) + ELEM_IDX_W'(gi);
      assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_en[gi] ? tile_reg[elem_idx] : '0;
    end
  endgenerate

endmodule

// File: rtl/tile_store_engine.sv
// Streams tiles from a vector buffer to DRAM as element beats with partial-beat enables.
// Optional macro STORE_STALL_CNT_EN adds a saturating backpressure cycle counter.
module tile_store_engine
  import store_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int BEAT_ELEMS = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            dram_addr,
  input  logic [LEN_WIDTH-1:0]             length,
  input  logic [ADDR_WIDTH-1:0]            tile_stride,
  input  logic [4:0]                       buf_id,
  output logic                             buf_read_en,
  output logic [4:0]                       buf_read_id,
  input  logic [DATA_WIDTH-1:0]            buf_read_data [TILE_ELEMS],
  input  logic                             buf_read_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BEAT_ELEMS*DATA_WIDTH-1:0] mem_wdata,
  output logic [BEAT_ELEMS-1:0]            mem_be,
  input  logic                             mem_ready,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      stall_cnt
);

  localparam int BEATS_PER_TILE = TILE_ELEMS / BEAT_ELEMS;
  localparam int BEAT_IDX_W = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_TILE - 1);
  localparam logic [LEN_WIDTH-1:0] BEAT_LEN = LEN_WIDTH'(BEAT_ELEMS);

  store_state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] tile_base_reg;
  logic [ADDR_WIDTH-1:0] stride_reg;
  logic [LEN_WIDTH-1:0]  remaining_reg;
  logic [BEAT_IDX_W-1:0] beat_idx_reg;
  logic [4:0]            buf_id_reg;

  logic                  start_ok;
  logic                  capture;
  logic                  tile_last;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [BEAT_ELEMS-1:0] beat_mask;

  assign start_ok  = (state_reg == IDLE) && start;
  assign capture   = (state_reg == REQ_TILE) && buf_read_done;
  assign beat_cnt  = (remaining_reg >= BEAT_LEN) ? BEAT_LEN : remaining_reg;
  // A tile ends either at its last beat or when the transfer runs out of elements.
  assign tile_last = (beat_idx_reg == LAST_BEAT) || (remaining_reg == beat_cnt);
  assign beat_mask = BEAT_ELEMS'(be_mask(32'(beat_cnt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    buf_read_en = 1'b0;
    mem_req     = 1'b0;
    mem_be      = '0;
    mem_addr    = '0;
    done        = 1'b0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) state_next = (length == '0) ? FINISH : REQ_TILE;
      end
      REQ_TILE: begin
        buf_read_en = 1'b1;
        if (buf_read_done) state_next = WRITE;
      end
      WRITE: begin
        mem_req  = 1'b1;
        mem_be   = beat_mask;
        mem_addr = tile_base_reg + ADDR_WIDTH'(beat_idx_reg) * ADDR_WIDTH'(BEAT_ELEMS);
        if (mem_ready && tile_last) state_next = ADVANCE;
      end
      ADVANCE: begin
        state_next = (remaining_reg != '0) ? REQ_TILE : FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_we      = mem_req;
  assign buf_read_id = buf_id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_base_reg <= '0;
      stride_reg    <= '0;
      remaining_reg <= '0;
      beat_idx_reg  <= '0;
      buf_id_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            tile_base_reg <= dram_addr;
            stride_reg    <= tile_stride;
            remaining_reg <= length;
            buf_id_reg    <= buf_id;
            beat_idx_reg  <= '0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            remaining_reg <= remaining_reg - beat_cnt;
            if (!tile_last) beat_idx_reg <= beat_idx_reg + BEAT_IDX_W'(1);
          end
        end
        ADVANCE: begin
          beat_idx_reg <= '0;
          if (remaining_reg != '0) tile_base_reg <= tile_base_reg + stride_reg;
        end
        default: ;
      endcase
    end
  end

  tile_beat_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_ELEMS (TILE_ELEMS),
    .BEAT_ELEMS (BEAT_ELEMS),
    .BEAT_IDX_W (BEAT_IDX_W)
  ) u_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .tile_data (buf_read_data),
    .beat_idx  (beat_idx_reg),
    .lane_en   (mem_be),
    .beat_data (mem_wdata)
  );

`ifdef STORE_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (start_ok) begin
      stall_cnt_reg <= '0;
    end else if (mem_req && !mem_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tile_store_engine.sv
// Directed bench for tile_store_engine: table of transfers plus stall and
// mid-transfer reset sequences, with a beat monitor and tile responder.
module tb_tile_store_engine;

  localparam int AW = 24;
  localparam int DW = 8;
  localparam int TE = 32;
  localparam int BE = 4;
  localparam int LW = 16;

`ifdef STORE_STALL_CNT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] dram_addr = '0;
  logic [LW-1:0] length = '0;
  logic [AW-1:0] tile_stride = '0;
  logic [4:0]    buf_id = '0;
  logic          buf_read_en;
  logic [4:0]    buf_read_id;
  logic [DW-1:0] buf_read_data [TE];
  logic          buf_read_done = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BE*DW-1:0] mem_wdata;
  logic [BE-1:0] mem_be;
  logic          mem_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  tile_store_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dram_addr     (dram_addr),
    .length        (length),
    .tile_stride   (tile_stride),
    .buf_id        (buf_id),
    .buf_read_en   (buf_read_en),
    .buf_read_id   (buf_read_id),
    .buf_read_data (buf_read_data),
    .buf_read_done (buf_read_done),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ready     (mem_ready),
    .busy          (busy),
    .done          (done),
    .stall_cnt     (stall_cnt)
  );

  function automatic logic [7:0] tile_val(input int r, input int e);
    return 8'(r * 37 + e * 3 + 1);
  endfunction

  typedef struct {
    logic [AW-1:0]    addr;
    logic [BE-1:0]    be;
    logic [BE*DW-1:0] data;
    int               cyc;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [AW-1:0] stride;
    logic [4:0]    id;
    bit            poke;
    int            n_beats;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [BE-1:0] last_be;
    int            n_reads;
  } vec_t;

  beat_t beats[$];
  int cyc = 0, done_pulses = 0, done_cyc = 0, req_cycles = 0, en_cycles = 0;
  int we_err = 0, id_err = 0, stall_cycles = 0, stall_run = 0, unstable = 0;
  int stall_beat = -1, stall_len = 0;
  logic [4:0] exp_id = '0;
  logic [AW-1:0] hold_addr = '0;
  logic [BE*DW-1:0] hold_data = '0;
  logic [BE-1:0] hold_be = '0;

  // Beat monitor; also decides mem_ready for the current cycle.
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (mem_we != mem_req) we_err++;
    if (done) begin
      done_pulses++;
      done_cyc = cyc;
    end
    if (buf_read_en) begin
      en_cycles++;
      if (buf_read_id != exp_id) id_err++;
    end
    if (mem_req) begin
      req_cycles++;
      if (stall_run > 0 && (mem_addr != hold_addr || mem_wdata != hold_data || mem_be != hold_be))
        unstable++;
      hold_addr = mem_addr;
      hold_data = mem_wdata;
      hold_be   = mem_be;
      if (beats.size() == stall_beat && stall_run < stall_len) begin
        mem_ready = 1'b0;
        stall_run++;
        stall_cycles++;
      end else begin
        mem_ready = 1'b1;
        b.addr = mem_addr;
        b.be   = mem_be;
        b.data = mem_wdata;
        b.cyc  = cyc;
        beats.push_back(b);
        stall_run = 0;
      end
    end else begin
      mem_ready = 1'b1;
    end
  end

  // Tile responder: answers a read request after one wait cycle.
  int read_cnt = 0, rd_wait = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      buf_read_done = 1'b0;
      rd_wait = 0;
    end else if (buf_read_done) begin
      buf_read_done = 1'b0;
      read_cnt++;
    end else if (buf_read_en) begin
      if (rd_wait < 1) begin
        rd_wait++;
      end else begin
        rd_wait = 0;
        for (int e = 0; e < TE; e++) buf_read_data[e] = tile_val(read_cnt, e);
        buf_read_done = 1'b1;
      end
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_xfer(input vec_t v, output bit timed_out);
    int d0;
    d0 = done_pulses;
    @(posedge clk); #1;
    exp_id = v.id; dram_addr = v.addr; length = v.len; tile_stride = v.stride; buf_id = v.id;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.poke) begin
      repeat (2) @(posedge clk); #1;
      dram_addr = 24'h000555; length = 16'd4; buf_id = v.id ^ 5'h1F; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; dram_addr = v.addr; length = v.len; buf_id = v.id;
    end
    timed_out = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (done_pulses > d0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    int b0, r0, d0, e0, q0, nb, errs;
    bit to;
    b0 = beats.size(); r0 = read_cnt; d0 = done_pulses; e0 = en_cycles; q0 = req_cycles;
    run_xfer(v, to);
    nb = beats.size() - b0;
    check({tag, "_timeout"}, longint'(to), 0);
    check({tag, "_beats"}, nb, v.n_beats);
    if (nb > 0 && v.n_beats > 0) begin
      check({tag, "_first_addr"}, beats[b0].addr, v.first_addr);
      check({tag, "_last_addr"}, beats[beats.size()-1].addr, v.last_addr);
      check({tag, "_last_be"}, beats[beats.size()-1].be, v.last_be);
      check({tag, "_done_latency"}, done_cyc - beats[beats.size()-1].cyc, 2);
    end
    if (v.n_beats == 0) check({tag, "_req_cycles"}, req_cycles - q0, 0);
    check({tag, "_reads"}, read_cnt - r0, v.n_reads);
    check({tag, "_en_cycles"}, en_cycles - e0, 2 * v.n_reads);
    check({tag, "_done_pulses"}, done_pulses - d0, 1);
    errs = 0;
    for (int j = 0; j < nb; j++) begin
      logic [AW-1:0]    ea;
      logic [BE-1:0]    eb;
      logic [BE*DW-1:0] ed;
      int r, bi;
      r = j / (TE / BE);
      bi = j % (TE / BE);
      ea = v.addr + AW'(r) * v.stride + AW'(bi * BE);
      eb = '0;
      ed = '0;
      for (int k = 0; k < BE; k++) begin
        if (j * BE + k < int'(v.len)) begin
          eb[k] = 1'b1;
          ed[k*DW +: DW] = tile_val(r0 + r, bi * BE + k);
        end
      end
      if (beats[b0+j].addr != ea || beats[b0+j].be != eb || beats[b0+j].data != ed) errs++;
    end
    check({tag, "_beat_contents"}, errs, 0);
    $display("xfer %s: addr=0x%06h len=%0d beats=%0d reads=%0d", tag, v.addr, v.len, nb, read_cnt - r0);
  endtask

  vec_t vecs[6];

  initial begin
    int b0, s0, u0, d0;
    bit to;
    vec_t sv, pr;

    vecs[0] = '{24'h000100, 16'd8,  24'd32,    5'd1, 1'b0, 2,  24'h000100, 24'h000104, 4'hF, 1};
    vecs[1] = '{24'h000100, 16'd35, 24'd32,    5'd2, 1'b0, 9,  24'h000100, 24'h000120, 4'h7, 2};
    vecs[2] = '{24'hFFFFFC, 16'd8,  24'd32,    5'd3, 1'b0, 2,  24'hFFFFFC, 24'h000000, 4'hF, 1};
    vecs[3] = '{24'h000700, 16'd0,  24'd32,    5'd4, 1'b0, 0,  24'h000000, 24'h000000, 4'h0, 0};
    vecs[4] = '{24'h000200, 16'd6,  24'h000040, 5'd6, 1'b1, 2,  24'h000200, 24'h000204, 4'h3, 1};
    vecs[5] = '{24'h001000, 16'd70, 24'h000100, 5'd7, 1'b0, 18, 24'h001000, 24'h001204, 4'h3, 3};

    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_buf_read_en", buf_read_en, 0);
    check("rst_done", done, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_and_check(vecs[i], $sformatf("v%0d", i));

    // Backpressure on beat 1: three cycles of mem_ready low.
    sv = '{24'h000300, 16'd8, 24'd32, 5'd8, 1'b0, 2, 24'h000300, 24'h000304, 4'hF, 1};
    b0 = beats.size(); s0 = stall_cycles; u0 = unstable;
    stall_beat = b0 + 1;
    stall_len = 3;
    run_xfer(sv, to);
    stall_beat = -1;
    check("stall_timeout", longint'(to), 0);
    check("stall_beats", beats.size() - b0, 2);
    check("stall_cycles_seen", stall_cycles - s0, 3);
    check("stall_stable", unstable - u0, 0);
    check("stall_cnt", stall_cnt, EXP_STALL);
    if (beats.size() >= b0 + 2) check("stall_beat1_addr", beats[b0+1].addr, 24'h000304);
    $display("stall xfer: stall_cnt=%0d", stall_cnt);
    sv = '{24'h000340, 16'd4, 24'd32, 5'd8, 1'b0, 1, 24'h000340, 24'h000340, 4'hF, 1};
    run_and_check(sv, "after_stall");
    check("stall_cnt_cleared", stall_cnt, 0);

    // Reset while beat 3 is presented.
    b0 = beats.size(); d0 = done_pulses;
    @(posedge clk); #1;
    exp_id = 5'd9; dram_addr = 24'h000500; length = 16'd32; tile_stride = 24'd32; buf_id = 5'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (beats.size() >= b0 + 3) begin
        to = 1'b0;
        break;
      end
    end
    check("rst_mid_timeout", longint'(to), 0);
    check("pre_rst_mem_req", mem_req, 1);
    check("pre_rst_mem_addr", mem_addr, 24'h00050C);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_mem_be", mem_be, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_buf_read_en", buf_read_en, 0);
    check("mid_rst_buf_read_id", buf_read_id, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_done", done_pulses - d0, 0);
    $display("reset mid-transfer: beats before reset=%0d", beats.size() - b0);
    pr = '{24'h000400, 16'd8, 24'd32, 5'd2, 1'b0, 2, 24'h000400, 24'h000404, 4'hF, 1};
    run_and_check(pr, "post_rst");

    check("mem_we_tracks_req", we_err, 0);
    check("buf_read_id_latched", id_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_store_engine.md
TILE_STORE_ENGINE -- requirements
Module: tile_store_engine

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
 - ADDR_WIDTH, 24, DRAM element address width.
 - DATA_WIDTH, 8, element width.
 - TILE_WIDTH, 256, buffer tile width in bits.
 - TILE_ELEMS, TILE_WIDTH/DATA_WIDTH, elements per tile.
 - BEAT_ELEMS, 4, elements per memory beat; TILE_ELEMS SHALL be a multiple of BEAT_ELEMS.
 - LEN_WIDTH, 16, length field width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
 - clk, in, 1, single clock.
 - rst_n, in, 1, asynchronous active-low reset.
 - start, in, 1, begin transfer (sampled in IDLE only).
 - dram_addr, in, ADDR_WIDTH, first element address.
 - length, in, LEN_WIDTH, elements to store.
 - tile_stride, in, ADDR_WIDTH, address increment between tiles.
 - buf_id, in, 5, source vector buffer.
 - buf_read_en, out, 1, tile read request.
 - buf_read_id, out, 5, equals latched buf_id.
 - buf_read_data, in, DATA_WIDTH x TILE_ELEMS, unpacked tile.
 - buf_read_done, in, 1, tile valid this cycle.
 - mem_req, out, 1, beat valid.
 - mem_we, out, 1, equals mem_req.
 - mem_addr, out, ADDR_WIDTH, beat address.
 - mem_wdata, out, BEAT_ELEMS*DATA_WIDTH, element 0 in LSBs.
 - mem_be, out, BEAT_ELEMS, per-element enable.
 - mem_ready, in, 1, beat accepted when mem_req and mem_ready are both high.
 - busy, out, 1, high outside IDLE.
 - done, out, 1, one-cycle completion pulse.
 - stall_cnt, out, 16, backpressure cycle count.

Function
REQ-003 States SHALL be IDLE, REQ_TILE, WRITE, ADVANCE, FINISH.
REQ-004 IDLE: on start, SHALL latch dram_addr, length, tile_stride, buf_id and clear the counters; go to FINISH if length==0, else to REQ_TILE.
REQ-005 start SHALL be ignored while busy.
REQ-006 REQ_TILE: buf_read_en SHALL be held high until buf_read_done; on that cycle the tile SHALL be captured into a local register and the FSM SHALL enter WRITE.
REQ-007 WRITE: mem_req SHALL stay high, with mem_addr, mem_wdata and mem_be stable, until mem_ready; each accepted beat advances the beat index next cycle.
REQ-008 Beat address SHALL be tile_base + beat_idx*BEAT_ELEMS, modulo 2^ADDR_WIDTH.
REQ-009 Element count per beat SHALL be min(BEAT_ELEMS, remaining); mem_be SHALL set that many LSBs; disabled wdata lanes SHALL be zero.
REQ-010 After the last beat of a tile, or when remaining reaches 0, the FSM SHALL enter ADVANCE.
REQ-011 ADVANCE: if remaining>0, tile_base += tile_stride (wrapping) and go to REQ_TILE; else go to FINISH.
REQ-012 FINISH: done SHALL be high for exactly one cycle, then the FSM returns to IDLE; done SHALL rise the cycle after the final accepted beat plus one (ADVANCE).
REQ-013 No buf_read_en and no mem_req SHALL occur for length==0.
REQ-014 mem_req SHALL NOT be asserted outside WRITE.

Reset
REQ-015 On rst_n low (asynchronous), the FSM SHALL go to IDLE and all outputs and counters SHALL go to 0, including mid-transfer; no partial beat is resumed.

Configuration
REQ-016 With STORE_STALL_CNT_EN defined, stall_cnt SHALL increment (saturating at 0xFFFF) each cycle mem_req&&!mem_ready and clear on accepted start.
REQ-017 Without STORE_STALL_CNT_EN, stall_cnt SHALL be constant 0 with no counter logic.

Structure
REQ-018 The state enum and the beat-enable mask helper SHALL live in shared package store_pkg.
REQ-019 The tile capture register and beat lane mux SHALL be a sub-module, tile_beat_mux.

Verification
REQ-020 Directed scenarios (TILE_ELEMS=32, BEAT_ELEMS=4):
 - addr=0x100, len=8, ready=1 -> beats 0x100 and 0x104, be=0xF, one done.
 - addr=0x100, len=35, stride=32 -> 8 beats from 0x100 to 0x11C, second tile read, beat 0x120 with be=0x7.
 - ready low 3 cycles on beat 1 -> addr and data stable, stall_cnt=3 (macro on) or 0 (macro off).
 - len=0 -> no buf_read_en, no mem_req, done pulse once.
 - rst_n low during beat 3 -> all outputs 0; a new start afterwards completes normally.
 - addr=0xFFFFFC, len=8 -> beats 0xFFFFFC then 0x000000.
